// File: rtl/anc_ui_pkg.sv
// Shared constants for the ANC push-button UI: FSM state codes,
// debounced button encodings and step directions.
package anc_ui_pkg;

  // FSM state encoding
  localparam int unsigned ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_HELD   = 3'd1;
  localparam logic [ST_W-1:0] ST_REPEAT = 3'd2;
  localparam logic [ST_W-1:0] ST_BOTH   = 3'd3;
  localparam logic [ST_W-1:0] ST_LOCK   = 3'd4;

  // Button vector encodings: bit0 = UP, bit1 = DOWN
  localparam logic [1:0] BTN_NONE = 2'b00;
  localparam logic [1:0] BTN_UP   = 2'b01;
  localparam logic [1:0] BTN_DN   = 2'b10;
  localparam logic [1:0] BTN_BOTH = 2'b11;

  // Step directions
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // Direction implied by a single pressed button
  function automatic logic btn_dir(input logic [1:0] b);
    return (b == BTN_DN) ? DIR_DN : DIR_UP;
  endfunction

endpackage

// File: rtl/anc_cfg_pusher.sv
// Configuration write channel: tracks a dirty flag and presents the latest
// gain/enable on a valid/ready channel, coalescing changes made while a
// write is outstanding.
// Ports:
//   clk, rst        - clock, async active-high reset
//   chg             - live gain/enable changes value at this edge
//   gain, en        - live (pre-edge) gain index and enable
//   cfg_ready       - datapath accepts the write
//   cfg_valid       - write valid
//   cfg_gain/cfg_en - write payload, stable while waiting for ready
module anc_cfg_pusher #(
  parameter int unsigned GAIN_W   = 4,
  parameter int unsigned GAIN_RST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              chg,
  input  logic [GAIN_W-1:0] gain,
  input  logic              en,
  input  logic              cfg_ready,
  output logic              cfg_valid,
  output logic [GAIN_W-1:0] cfg_gain,
  output logic              cfg_en
);

  logic dirty;
  logic load_c;

  // A new write is loaded only from an idle channel
  assign load_c = !cfg_valid && dirty;

  // Payload register and dirty tracking; dirty resets high so the defaults go out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_valid <= 1'b0;
      cfg_gain  <= GAIN_W'(GAIN_RST);
      cfg_en    <= 1'b1;
      dirty     <= 1'b1;
    end else begin
      if (cfg_valid && cfg_ready) begin
        cfg_valid <= 1'b0;
      end else if (load_c) begin
        cfg_valid <= 1'b1;
        cfg_gain  <= gain;
        cfg_en    <= en;
      end
      // A change at the load edge re-arms dirty; the load took the old value
      if (chg) begin
        dirty <= 1'b1;
      end else if (load_c) begin
        dirty <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/anc_ui_ctrl.sv
// ANC push-button UI controller: steps a saturating gain index on UP/DOWN
// (press plus auto-repeat), toggles ANC enable on a long both-button hold,
// and pushes every configuration change over a valid/ready write channel.
// Ports:
//   clk, rst        - clock, async active-high reset
//   btn             - debounced buttons, bit0 = UP, bit1 = DOWN
//   cfg_valid/ready - configuration write handshake
//   cfg_gain/cfg_en - configuration write payload
//   gain_idx/anc_en - live gain index and enable
module anc_ui_ctrl
  import anc_ui_pkg::*;
#(
  parameter int unsigned GAIN_W        = 4,
  parameter int unsigned GAIN_MAX      = 15,
  parameter int unsigned GAIN_RST      = 8,
  parameter int unsigned HOLD_CYCLES   = 25000000,
  parameter int unsigned REPEAT_CYCLES = 5000000,
  parameter int unsigned TOGGLE_CYCLES = 50000000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        btn,
  output logic              cfg_valid,
  input  logic              cfg_ready,
  output logic [GAIN_W-1:0] cfg_gain,
  output logic              cfg_en,
  output logic [GAIN_W-1:0] gain_idx,
  output logic              anc_en
);

  localparam logic [CNT_W-1:0]  HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TOGGLE_LAST = CNT_W'(TOGGLE_CYCLES - 1);
  localparam logic [GAIN_W-1:0] GAIN_TOP    = GAIN_W'(GAIN_MAX);

  logic [ST_W-1:0]   state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              dir, dir_nxt;
  logic [GAIN_W-1:0] gain_nxt;
  logic              en_nxt;
  logic              step_c;
  logic              chg_c;
  logic [CNT_W-1:0]  thr_c;

  // State, counter, held direction and live configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dir      <= DIR_UP;
      gain_idx <= GAIN_W'(GAIN_RST);
      anc_en   <= 1'b1;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dir      <= dir_nxt;
      gain_idx <= gain_nxt;
      anc_en   <= en_nxt;
    end
  end

  // Next-state, counter and saturating gain/enable update
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dir_nxt   = dir;
    gain_nxt  = gain_idx;
    en_nxt    = anc_en;
    step_c    = 1'b0;
    thr_c     = (state == ST_HELD) ? HOLD_LAST : REPEAT_LAST;

    case (state)
      ST_IDLE: begin
        case (btn)
          BTN_UP, BTN_DN: begin
            step_c    = 1'b1;
            dir_nxt   = btn_dir(btn);
            state_nxt = ST_HELD;
            cnt_nxt   = '0;
          end
          BTN_BOTH: begin
            state_nxt = ST_BOTH;
            cnt_nxt   = '0;
          end
          default: ;
        endcase
      end

      ST_HELD, ST_REPEAT: begin
        if (btn == BTN_NONE) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (btn == BTN_BOTH) begin
          state_nxt = ST_BOTH;
          cnt_nxt   = '0;
        end else if (btn_dir(btn) != dir) begin
          // Rolling from one button to the other locks out until release
          state_nxt = ST_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == thr_c) begin
          step_c    = 1'b1;
          state_nxt = ST_REPEAT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_BOTH: begin
        if (btn != BTN_BOTH) begin
          state_nxt = ST_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == TOGGLE_LAST) begin
          en_nxt    = ~anc_en;
          state_nxt = ST_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_LOCK: begin
        if (btn == BTN_NONE) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Saturating step; at a limit the index holds and no change is flagged
    if (step_c) begin
      if (dir_nxt == DIR_UP) begin
        if (gain_idx != GAIN_TOP) gain_nxt = gain_idx + GAIN_W'(1);
      end else begin
        if (gain_idx != '0) gain_nxt = gain_idx - GAIN_W'(1);
      end
    end
  end

  assign chg_c = (gain_nxt != gain_idx) || (en_nxt != anc_en);

  anc_cfg_pusher #(
    .GAIN_W   (GAIN_W),
    .GAIN_RST (GAIN_RST)
  ) u_pusher (
    .clk       (clk),
    .rst       (rst),
    .chg       (chg_c),
    .gain      (gain_idx),
    .en        (anc_en),
    .cfg_ready (cfg_ready),
    .cfg_valid (cfg_valid),
    .cfg_gain  (cfg_gain),
    .cfg_en    (cfg_en)
  );

endmodule

// File: tb/tb_anc_ui_ctrl.sv
// Self-checking bench for anc_ui_ctrl against a run-length reference model.
module tb_anc_ui_ctrl;

  localparam int unsigned GAIN_W   = 4;
  localparam int          GAIN_MAX = 15;
  localparam int          GAIN_RST = 8;
  localparam int          HOLD     = 8;
  localparam int          REPEAT   = 4;
  localparam int          TOGGLE   = 6;
  localparam int unsigned CNT_W    = 8;

  logic              clk;
  logic              rst;
  logic [1:0]        btn;
  logic              cfg_ready;
  logic              cfg_valid;
  logic [GAIN_W-1:0] cfg_gain;
  logic              cfg_en;
  logic [GAIN_W-1:0] gain_idx;
  logic              anc_en;

  anc_ui_ctrl #(
    .GAIN_W        (GAIN_W),
    .GAIN_MAX      (GAIN_MAX),
    .GAIN_RST      (GAIN_RST),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REPEAT),
    .TOGGLE_CYCLES (TOGGLE),
    .CNT_W         (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn       (btn),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_gain  (cfg_gain),
    .cfg_en    (cfg_en),
    .gain_idx  (gain_idx),
    .anc_en    (anc_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Observed handshakes on the write channel
  int                dut_wr;
  logic [GAIN_W-1:0] wr_gain_q[$];
  logic              wr_en_q[$];

  always @(posedge clk) begin
    if (!rst && cfg_valid && cfg_ready) begin
      dut_wr = dut_wr + 1;
      wr_gain_q.push_back(cfg_gain);
      wr_en_q.push_back(cfg_en);
    end
  end

  // Reference model: press run-length arithmetic plus a channel model
  // mode: 0 released, 1 single button run, 2 both-button run, 3 locked out
  int                m_mode;
  logic [1:0]        m_btn;
  int                m_run;
  int                m_gain;
  logic              m_en;
  logic              m_valid;
  logic [GAIN_W-1:0] m_pg;
  logic              m_pe;
  logic              m_dirty;

  wire [10:0] obs_vec = {cfg_valid, cfg_gain, cfg_en, gain_idx, anc_en};
  localparam logic [10:0] RST_VEC = {1'b0, 4'd8, 1'b1, 4'd8, 1'b1};

  function automatic logic [10:0] exp_vec();
    return {m_valid, m_pg, m_pe, GAIN_W'(m_gain), m_en};
  endfunction

  // Steps happen at run offsets 0, HOLD, HOLD+REPEAT, HOLD+2*REPEAT, ...
  function automatic bit step_due(input int m);
    return (m == HOLD) || (m > HOLD && ((m - HOLD) % REPEAT) == 0);
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_btn   = 2'b00;
    m_run   = 0;
    m_gain  = GAIN_RST;
    m_en    = 1'b1;
    m_valid = 1'b0;
    m_pg    = GAIN_W'(GAIN_RST);
    m_pe    = 1'b1;
    m_dirty = 1'b1;
  endtask

  task automatic model_edge(input logic [1:0] b, input logic r);
    int   og;
    logic oe;
    bit   step;
    bit   load;
    og   = m_gain;
    oe   = m_en;
    step = 0;
    case (m_mode)
      0: begin
        if (b == 2'b01 || b == 2'b10) begin
          step = 1; m_mode = 1; m_btn = b; m_run = 0;
        end else if (b == 2'b11) begin
          m_mode = 2; m_run = 0;
        end
      end
      1: begin
        if (b == 2'b00) m_mode = 0;
        else if (b == 2'b11) begin m_mode = 2; m_run = 0; end
        else if (b != m_btn) m_mode = 3;
        else begin
          m_run = m_run + 1;
          if (step_due(m_run)) step = 1;
        end
      end
      2: begin
        if (b == 2'b11) begin
          m_run = m_run + 1;
          if (m_run == TOGGLE) begin m_en = !m_en; m_mode = 3; end
        end else m_mode = 3;
      end
      default: if (b == 2'b00) m_mode = 0;
    endcase
    if (step) begin
      if (m_btn == 2'b01) begin if (m_gain < GAIN_MAX) m_gain = m_gain + 1; end
      else begin if (m_gain > 0) m_gain = m_gain - 1; end
    end
    load = !m_valid && m_dirty;
    if (m_valid && r) m_valid = 1'b0;
    else if (load) begin m_valid = 1'b1; m_pg = GAIN_W'(og); m_pe = oe; end
    if (m_gain != og || m_en != oe) m_dirty = 1'b1;
    else if (load) m_dirty = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, settle
  task automatic tick(input logic [1:0] b, input logic r);
    btn       = b;
    cfg_ready = r;
    @(posedge clk);
    model_edge(b, r);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; btn = 2'b00; cfg_ready = 1'b1;
    #1;
    n_chk++;
    if (obs_vec !== RST_VEC) begin
      n_fail++; $display("FAIL reset_vals: got %b expected %b", obs_vec, RST_VEC);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(2'b00, 1'b1);
    n_chk++;
    if (obs_vec !== 11'b1_1000_1_1000_1 || obs_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_push: got %b expected %b", obs_vec, 11'b1_1000_1_1000_1);
    end
    tick(2'b00, 1'b1);
    n_chk++;
    if (obs_vec !== RST_VEC) begin
      n_fail++; $display("FAIL reset_push_done: got %b expected %b", obs_vec, RST_VEC);
    end
  endtask

  task automatic test_single_press();
    int w0;
    w0 = dut_wr;
    tick(2'b01, 1'b1);
    n_chk++;
    if (gain_idx !== 4'd9) begin
      n_fail++; $display("FAIL press_gain: got %0d expected 9", gain_idx);
    end
    for (int i = 0; i < 6; i++) begin
      tick(2'b00, 1'b1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL press_cycle%0d: got %b expected %b", i, obs_vec, exp_vec());
      end
    end
    n_chk++;
    if (dut_wr - w0 != 1 || wr_gain_q[$] !== 4'd9) begin
      n_fail++; $display("FAIL press_write: got %0d writes last %0d expected 1 write of 9",
                         dut_wr - w0, wr_gain_q[$]);
    end
  endtask

  task automatic test_hold_repeat();
    tick(2'b10, 1'b1);
    repeat (3) tick(2'b00, 1'b1);
    n_chk++;
    if (gain_idx !== 4'd8) begin
      n_fail++; $display("FAIL hold_start: got %0d expected 8", gain_idx);
    end
    for (int i = 0; i < 20; i++) begin
      tick(2'b01, 1'b1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL hold_cycle%0d: got %b expected %b", i, obs_vec, exp_vec());
      end
    end
    tick(2'b00, 1'b1);
    n_chk++;
    if (gain_idx !== 4'd12) begin
      n_fail++; $display("FAIL hold_gain: got %0d expected 12", gain_idx);
    end
  endtask

  task automatic test_saturation();
    int w0;
    for (int i = 0; i < 200 && m_gain < GAIN_MAX; i++) tick(2'b01, 1'b1);
    repeat (4) tick(2'b00, 1'b1);
    w0 = dut_wr;
    for (int i = 0; i < 20; i++) begin
      tick(2'b01, 1'b1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL sat_hi_cycle%0d: got %b expected %b", i, obs_vec, exp_vec());
      end
    end
    repeat (3) tick(2'b00, 1'b1);
    n_chk++;
    if (gain_idx !== 4'd15 || dut_wr != w0) begin
      n_fail++; $display("FAIL sat_hi: got gain %0d writes %0d expected 15 and 0", gain_idx, dut_wr - w0);
    end
    for (int i = 0; i < 200 && m_gain > 0; i++) tick(2'b10, 1'b1);
    repeat (4) tick(2'b00, 1'b1);
    w0 = dut_wr;
    for (int i = 0; i < 20; i++) tick(2'b10, 1'b1);
    repeat (3) tick(2'b00, 1'b1);
    n_chk++;
    if (gain_idx !== 4'd0 || dut_wr != w0) begin
      n_fail++; $display("FAIL sat_lo: got gain %0d writes %0d expected 0 and 0", gain_idx, dut_wr - w0);
    end
  endtask

  task automatic test_toggle();
    for (int i = 0; i < TOGGLE + 1; i++) begin
      tick(2'b11, 1'b1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL tog_cycle%0d: got %b expected %b", i, obs_vec, exp_vec());
      end
    end
    repeat (4) tick(2'b00, 1'b1);
    n_chk++;
    if (anc_en !== 1'b0 || wr_en_q[$] !== 1'b0) begin
      n_fail++; $display("FAIL tog_once: got en %b wr_en %b expected 0 0", anc_en, wr_en_q[$]);
    end
    for (int i = 0; i < 20; i++) tick(2'b11, 1'b1);
    repeat (4) tick(2'b00, 1'b1);
    n_chk++;
    if (anc_en !== 1'b1 || obs_vec !== exp_vec()) begin
      n_fail++; $display("FAIL tog_long: got en %b expected single toggle to 1", anc_en);
    end
    // Short both-hold then roll to UP: no toggle, no step until re-press
    repeat (3) tick(2'b11, 1'b1);
    for (int i = 0; i < 5; i++) tick(2'b01, 1'b1);
    n_chk++;
    if (gain_idx !== 4'd0 || anc_en !== 1'b1) begin
      n_fail++; $display("FAIL tog_abort: got gain %0d en %b expected 0 1", gain_idx, anc_en);
    end
    repeat (2) tick(2'b00, 1'b1);
    tick(2'b01, 1'b1);
    tick(2'b00, 1'b1);
    n_chk++;
    if (gain_idx !== 4'd1 || obs_vec !== exp_vec()) begin
      n_fail++; $display("FAIL tog_repress: got gain %0d expected 1", gain_idx);
    end
  endtask

  task automatic test_reset_mid();
    tick(2'b01, 1'b0);
    tick(2'b01, 1'b0);
    tick(2'b01, 1'b0);
    rst = 1'b1;
    #1;
    n_chk++;
    if (obs_vec !== RST_VEC) begin
      n_fail++; $display("FAIL mid_reset: got %b expected %b", obs_vec, RST_VEC);
    end
    btn = 2'b00; cfg_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick(2'b00, 1'b1);
    n_chk++;
    if (obs_vec !== 11'b1_1000_1_1000_1 || obs_vec !== exp_vec()) begin
      n_fail++; $display("FAIL mid_reissue: got %b expected %b", obs_vec, 11'b1_1000_1_1000_1);
    end
    repeat (2) tick(2'b00, 1'b1);
  endtask

  task automatic test_coalesce();
    int q0;
    q0 = wr_gain_q.size();
    for (int p = 0; p < 3; p++) begin
      tick(2'b01, 1'b0);
      for (int i = 0; i < 2; i++) begin
        tick(2'b00, 1'b0);
        n_chk++;
        if (cfg_valid !== 1'b1 || cfg_gain !== 4'd9 || obs_vec !== exp_vec()) begin
          n_fail++; $display("FAIL coal_hold%0d: got v=%b g=%0d expected v=1 g=9", p, cfg_valid, cfg_gain);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      tick(2'b00, 1'b1);
      n_chk++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL coal_drain%0d: got %b expected %b", i, obs_vec, exp_vec());
      end
    end
    n_chk++;
    if (wr_gain_q.size() - q0 != 2 || wr_gain_q[q0] !== 4'd9 || wr_gain_q[q0+1] !== 4'd11) begin
      n_fail++; $display("FAIL coal_seq: got %0d writes expected 9 then 11", wr_gain_q.size() - q0);
    end
  endtask

  task automatic test_random();
    logic [1:0] b;
    logic       r;
    b = 2'b00;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 12) b = 2'($urandom_range(0, 3));
      r = ($urandom_range(0, 99) < 70);
      tick(b, r);
      n_chk++;
      if (obs_vec !== exp_vec()) begin
        n_fail++; $display("FAIL rand_cycle%0d: got %b expected %b", i, obs_vec, exp_vec());
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    dut_wr = 0;
    model_reset();
    test_reset();
    test_single_press();
    test_hold_repeat();
    test_saturation();
    test_toggle();
    test_reset_mid();
    test_coalesce();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
